// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : pixel_compositor
// Brief    : Two-stage prioritised RGB layer compositor over a split background,
//            with a frame-synchronous double-buffered layer mask.
//            Optional per-frame layer pixel counter: COMPOSITOR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int RGB_BITS   = 6,
    parameter int BG_SPLIT   = 320,
    parameter int STAT_LAYER = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [9:0]                       i_hpos,
    input  logic [9:0]                       i_vpos,
    input  logic                             i_visible,
    input  logic [1:0]                       i_sync,
    input  logic [NUM_LAYERS-1:0]            i_layer_en,
    input  logic [NUM_LAYERS*RGB_BITS-1:0]   i_layer_rgb,
    input  logic [RGB_BITS-1:0]              i_bg_left,
    input  logic [RGB_BITS-1:0]              i_bg_right,
    input  logic                             i_mask_wr,
    input  logic [NUM_LAYERS-1:0]            i_mask_data,
    input  logic                             i_frame_end,
    output logic [RGB_BITS-1:0]              o_rgb,
    output logic [1:0]                       o_sync,
    output logic [9:0]                       o_hpos,
    output logic [9:0]                       o_vpos,
    output logic [NUM_LAYERS-1:0]            o_mask,
    output logic                             o_mask_pending,
    output logic [18:0]                      o_stat
);

    localparam logic [10:0] c_BG_SPLIT = 11'(BG_SPLIT);

    if (STAT_LAYER < 0 || STAT_LAYER >= NUM_LAYERS) begin : g_bad_stat_layer
        $error("pixel_compositor: STAT_LAYER out of range");
    end

    logic [NUM_LAYERS-1:0]          r_mask_active;
    logic [NUM_LAYERS-1:0]          r_mask_pending;
    logic                           r_mask_flag;

    logic                           r_s1_visible;
    logic [1:0]                     r_s1_sync;
    logic [9:0]                     r_s1_hpos;
    logic [9:0]                     r_s1_vpos;
    logic [NUM_LAYERS-1:0]          r_s1_en;
    logic [NUM_LAYERS*RGB_BITS-1:0] r_s1_rgb;
    logic [RGB_BITS-1:0]            r_s1_bg;

    logic                           w_hit;
    logic [RGB_BITS-1:0]            w_win_rgb;
    logic [RGB_BITS-1:0]            w_pix;

    // A write coinciding with frame end still promotes the old pending value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask_active  <= '1;
            r_mask_pending <= '0;
            r_mask_flag    <= 1'b0;
        end else begin
            if (i_frame_end && r_mask_flag) begin
                r_mask_active <= r_mask_pending;
            end
            if (i_mask_wr) begin
                r_mask_pending <= i_mask_data;
                r_mask_flag    <= 1'b1;
            end else if (i_frame_end) begin
                r_mask_flag    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_visible <= 1'b0;
            r_s1_sync    <= '0;
            r_s1_hpos    <= '0;
            r_s1_vpos    <= '0;
            r_s1_en      <= '0;
            r_s1_rgb     <= '0;
            r_s1_bg      <= '0;
        end else begin
            r_s1_visible <= i_visible;
            r_s1_sync    <= i_sync;
            r_s1_hpos    <= i_hpos;
            r_s1_vpos    <= i_vpos;
            r_s1_en      <= i_layer_en & r_mask_active;
            r_s1_rgb     <= i_layer_rgb;
            r_s1_bg      <= ({1'b0, i_hpos} < c_BG_SPLIT) ? i_bg_left : i_bg_right;
        end
    end

    // Scan from lowest priority upward so the lowest set index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_win_rgb = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (r_s1_en[k]) begin
                w_hit     = 1'b1;
                w_win_rgb = r_s1_rgb[k*RGB_BITS +: RGB_BITS];
            end
        end
        w_pix = !r_s1_visible ? '0 : (w_hit ? w_win_rgb : r_s1_bg);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_rgb  <= '0;
            o_sync <= '0;
            o_hpos <= '0;
            o_vpos <= '0;
        end else begin
            o_rgb  <= w_pix;
            o_sync <= r_s1_sync;
            o_hpos <= r_s1_hpos;
            o_vpos <= r_s1_vpos;
        end
    end

    assign o_mask         = r_mask_active;
    assign o_mask_pending = r_mask_flag;

`ifdef COMPOSITOR_STATS_EN
    localparam logic [NUM_LAYERS-1:0] c_STAT_ONEHOT = NUM_LAYERS'(1) << STAT_LAYER;
    localparam logic [NUM_LAYERS-1:0] c_STAT_BELOW  = c_STAT_ONEHOT - NUM_LAYERS'(1);

    logic [18:0] r_stat_cnt;
    logic        w_stat_hit;

    assign w_stat_hit = r_s1_visible && r_s1_en[STAT_LAYER] && ((r_s1_en & c_STAT_BELOW) == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_cnt <= '0;
            o_stat     <= '0;
        end else if (i_frame_end) begin
            o_stat     <= r_stat_cnt;
            r_stat_cnt <= '0;
        end else if (w_stat_hit && (r_stat_cnt != '1)) begin
            r_stat_cnt <= r_stat_cnt + 19'd1;
        end
    end
`else
    assign o_stat = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_compositor
// Brief    : Scoreboard bench for pixel_compositor (priority, background split,
//            mask double buffering, alignment, optional stats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_compositor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  i_hpos, i_vpos;
    logic        i_visible;
    logic [1:0]  i_sync;
    logic [3:0]  i_layer_en;
    logic [23:0] i_layer_rgb;
    logic [5:0]  i_bg_left, i_bg_right;
    logic        i_mask_wr;
    logic [3:0]  i_mask_data;
    logic        i_frame_end;
    logic [5:0]  o_rgb;
    logic [1:0]  o_sync;
    logic [9:0]  o_hpos, o_vpos;
    logic [3:0]  o_mask;
    logic        o_mask_pending;
    logic [18:0] o_stat;

    pixel_compositor dut (
        .clk(clk), .reset_n(reset_n),
        .i_hpos(i_hpos), .i_vpos(i_vpos), .i_visible(i_visible), .i_sync(i_sync),
        .i_layer_en(i_layer_en), .i_layer_rgb(i_layer_rgb),
        .i_bg_left(i_bg_left), .i_bg_right(i_bg_right),
        .i_mask_wr(i_mask_wr), .i_mask_data(i_mask_data), .i_frame_end(i_frame_end),
        .o_rgb(o_rgb), .o_sync(o_sync), .o_hpos(o_hpos), .o_vpos(o_vpos),
        .o_mask(o_mask), .o_mask_pending(o_mask_pending), .o_stat(o_stat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [5:0] rgb;
        logic [1:0] sync;
        logic [9:0] hpos;
        logic [9:0] vpos;
    } exp_t;
    exp_t sb[$];

    // Reference mask state
    logic [3:0] m_active, m_pending;
    logic       m_flag;

    localparam logic [23:0] LAYERS = {6'h2A, 6'h07, 6'h15, 6'h3F};

    function automatic logic [5:0] ref_rgb(input logic vis, input logic [9:0] h,
                                           input logic [3:0] en, input logic [23:0] rgbs,
                                           input logic [5:0] bl, input logic [5:0] br,
                                           input logic [3:0] mask);
        logic [3:0] m;
        if (!vis) return 6'h00;
        m = en & mask;
        for (int k = 0; k < 4; k++)
            if (m[k]) return rgbs[k*6 +: 6];
        return (h < 10'd320) ? bl : br;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("rgb",  {26'd0, o_rgb},  {26'd0, e.rgb});
            check_eq("sync", {30'd0, o_sync}, {30'd0, e.sync});
            check_eq("hpos", {22'd0, o_hpos}, {22'd0, e.hpos});
            check_eq("vpos", {22'd0, o_vpos}, {22'd0, e.vpos});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_hpos = '0; i_vpos = '0; i_visible = 1'b0; i_sync = 2'b11;
        i_layer_en = '0; i_layer_rgb = LAYERS; i_bg_left = 6'h2A; i_bg_right = 6'h15;
        i_mask_wr = 1'b0; i_mask_data = '0; i_frame_end = 1'b0;
    endtask

    task automatic send(input logic [9:0] h, input logic [9:0] v, input logic vis,
                        input logic [1:0] s, input logic [3:0] en,
                        input logic [5:0] bl, input logic [5:0] br, input logic [5:0] exp_rgb);
        exp_t e;
        i_hpos = h; i_vpos = v; i_visible = vis; i_sync = s;
        i_layer_en = en; i_layer_rgb = LAYERS; i_bg_left = bl; i_bg_right = br;
        e.due = cyc + 2; e.rgb = exp_rgb; e.sync = s; e.hpos = h; e.vpos = v;
        sb.push_back(e);
        tick();
    endtask

    task automatic send_ref(input logic [9:0] h, input logic [9:0] v, input logic vis,
                            input logic [1:0] s, input logic [3:0] en);
        send(h, v, vis, s, en, 6'h2A, 6'h15, ref_rgb(vis, h, en, LAYERS, 6'h2A, 6'h15, m_active));
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic mask_op(input logic wr, input logic [3:0] data, input logic fe);
        idle_inputs();
        i_mask_wr = wr; i_mask_data = data; i_frame_end = fe;
        tick();
        if (fe && m_flag) m_active = m_pending;
        if (wr) begin
            m_pending = data;
            m_flag    = 1'b1;
        end else if (fe) begin
            m_flag = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        // Reset with every input active
        reset_n = 1'b0;
        i_hpos = 10'd5; i_vpos = 10'd7; i_visible = 1'b1; i_sync = 2'b11;
        i_layer_en = 4'hF; i_layer_rgb = LAYERS; i_bg_left = 6'h3F; i_bg_right = 6'h3F;
        i_mask_wr = 1'b1; i_mask_data = 4'b0000; i_frame_end = 1'b1;
        repeat (3) tick();
        check_eq("rst_rgb",     {26'd0, o_rgb},  32'h0);
        check_eq("rst_sync",    {30'd0, o_sync}, 32'h0);
        check_eq("rst_hpos",    {22'd0, o_hpos}, 32'h0);
        check_eq("rst_mask",    {28'd0, o_mask}, 32'hF);
        check_eq("rst_pending", {31'd0, o_mask_pending}, 32'h0);
        check_eq("rst_stat",    {13'd0, o_stat}, 32'h0);
        idle_inputs();
        reset_n = 1'b1;
        m_active = 4'hF; m_pending = 4'h0; m_flag = 1'b0;
        tick();

        // Priority and background split
        send(10'd100, 10'd10, 1'b1, 2'b10, 4'b1010, 6'h2A, 6'h15, 6'h15);
        send(10'd319, 10'd10, 1'b1, 2'b01, 4'b0000, 6'h2A, 6'h15, 6'h2A);
        send(10'd320, 10'd11, 1'b1, 2'b00, 4'b0000, 6'h2A, 6'h15, 6'h15);
        send(10'd5,   10'd12, 1'b1, 2'b11, 4'b1000, 6'h00, 6'h00, 6'h2A);
        send(10'd6,   10'd12, 1'b1, 2'b11, 4'b0001, 6'h00, 6'h00, 6'h3F);
        send(10'd7,   10'd12, 1'b0, 2'b01, 4'b1111, 6'h2A, 6'h15, 6'h00);
        drain();

        // Mask write mid-frame stays pending until frame end
        mask_op(1'b1, 4'b1101, 1'b0);
        check_eq("pend_set",  {31'd0, o_mask_pending}, 32'h1);
        check_eq("mask_held", {28'd0, o_mask}, 32'hF);
        send(10'd100, 10'd20, 1'b1, 2'b11, 4'b0010, 6'h2A, 6'h15, 6'h15);
        drain();
        mask_op(1'b0, 4'b0000, 1'b1);
        check_eq("mask_swap",  {28'd0, o_mask}, 32'hD);
        check_eq("pend_clear", {31'd0, o_mask_pending}, 32'h0);
        send(10'd100, 10'd21, 1'b1, 2'b11, 4'b0010, 6'h2A, 6'h15, 6'h2A);
        send(10'd400, 10'd21, 1'b1, 2'b11, 4'b0110, 6'h2A, 6'h15, 6'h07);
        drain();

        // Simultaneous write and frame end
        mask_op(1'b1, 4'b0111, 1'b0);
        mask_op(1'b1, 4'b0011, 1'b1);
        check_eq("simul_mask", {28'd0, o_mask}, 32'h7);
        check_eq("simul_pend", {31'd0, o_mask_pending}, 32'h1);
        mask_op(1'b0, 4'b0000, 1'b1);
        check_eq("second_swap", {28'd0, o_mask}, 32'h3);
        mask_op(1'b0, 4'b0000, 1'b1);
        check_eq("fe_no_pend", {28'd0, o_mask}, 32'h3);
        check_eq("model_mask", {28'd0, o_mask}, {28'd0, m_active});

        // Random sweep: alignment, blanking, priority under mask 0011
        for (int i = 0; i < 40; i++) begin
            send_ref(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
                     1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom));
        end
        drain();

        // Stats frame: 1000 counted layer-0 hits
        mask_op(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 1200; i++) begin
            send_ref(10'(i % 640), 10'(i / 640), (i < 1100),
                     2'b11, (i < 1000) ? 4'b0001 : ((i < 1100) ? 4'b0010 : 4'b0001));
        end
        drain();
        mask_op(1'b0, 4'b0000, 1'b1);
`ifdef COMPOSITOR_STATS_EN
        check_eq("stat_1000", {13'd0, o_stat}, 32'd1000);
`else
        check_eq("stat_off", {13'd0, o_stat}, 32'd0);
`endif
        for (int i = 0; i < 50; i++) send_ref(10'(i), 10'd0, 1'b1, 2'b11, 4'b0000);
        drain();
        mask_op(1'b0, 4'b0000, 1'b1);
        check_eq("stat_zero", {13'd0, o_stat}, 32'd0);

        // Reset mid-frame flushes pipeline and mask
        mask_op(1'b1, 4'b0001, 1'b0);
        i_hpos = 10'd50; i_vpos = 10'd50; i_visible = 1'b1; i_layer_en = 4'b0001; i_sync = 2'b10;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check_eq("mrst_rgb",  {26'd0, o_rgb},  32'h0);
        check_eq("mrst_sync", {30'd0, o_sync}, 32'h0);
        check_eq("mrst_mask", {28'd0, o_mask}, 32'hF);
        check_eq("mrst_pend", {31'd0, o_mask_pending}, 32'h0);
        reset_n = 1'b1;
        m_active = 4'hF; m_pending = 4'h0; m_flag = 1'b0;
        idle_inputs();
        tick();
        send_ref(10'd50, 10'd50, 1'b1, 2'b01, 4'b0100);
        drain();
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
